// File: rtl/router_pkg.sv
// Shared types and constants for the router ingress packet transmitter.
package router_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StHeader,
    StPayload,
    StParity,
    StErrChk,
    StGap
  } tx_state_e;

  localparam logic [1:0]  ADDR_ILLEGAL = 2'b11;
  localparam int unsigned MAX_LEN      = 63;

  // Header byte as seen by the router: length in [7:2], destination in [1:0].
  function automatic logic [7:0] pack_header(input logic [5:0] len, input logic [1:0] addr);
    return {len, addr};
  endfunction

endpackage

// File: rtl/pkt_buf.sv
// Packet payload store: synchronous write, asynchronous read.
module pkt_buf #(
  parameter int unsigned Depth = 64,
  parameter int unsigned AddrW = 6
) (
  input  logic             clk_i,
  input  logic             wr_en_i,
  input  logic [AddrW-1:0] wr_ptr_i,
  input  logic [7:0]       wr_data_i,
  input  logic [AddrW-1:0] rd_ptr_i,
  output logic [7:0]       rd_data_o
);

  logic [7:0] mem_q [Depth];

  // Capture one payload byte per accepted handshake; contents need no reset.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_ptr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_ptr_i];

endmodule

// File: rtl/router_pkt_tx.sv
// Router ingress packet source: buffers a full packet, then sends header,
// payload and parity without bubbles, honouring busy and reporting err.
module router_pkt_tx
  import router_pkg::*;
#(
  parameter int unsigned MIN_GAP  = 2,
  parameter int unsigned ERR_WAIT = 3
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       tx_req,
  input  logic [1:0] tx_addr,
  input  logic [5:0] tx_len,
  input  logic       tx_inject_err,
  output logic       req_ready,
  output logic       tx_rej,
  input  logic       pld_valid,
  input  logic [7:0] pld_data,
  output logic       pld_ready,
  output logic       pkt_valid,
  output logic [7:0] data_out,
  input  logic       busy,
  input  logic       err,
  output logic       tx_done,
  output logic       tx_err
);

  localparam logic [7:0] ErrWaitInit = 8'(ERR_WAIT);
  localparam logic [7:0] MinGapInit  = 8'(MIN_GAP);

  tx_state_e  state_q;
  logic [1:0] addr_q;
  logic [5:0] len_q;
  logic       inject_q;
  logic [5:0] wr_ptr_q;
  logic [5:0] rd_ptr_q;
  logic [7:0] parity_q;
  logic [7:0] cnt_q;
  logic       sticky_q;
  logic [7:0] rd_data;
  logic       wr_en;

  assign req_ready = (state_q == StIdle);
  // Drops as soon as the count is complete, without waiting for a state change.
  assign pld_ready = (state_q == StLoad) && (wr_ptr_q != len_q);
  assign wr_en     = pld_valid && pld_ready;

  pkt_buf #(
    .Depth (MAX_LEN + 1),
    .AddrW (6)
  ) u_pkt_buf (
    .clk_i     (clock),
    .wr_en_i   (wr_en),
    .wr_ptr_i  (wr_ptr_q),
    .wr_data_i (pld_data),
    .rd_ptr_i  (rd_ptr_q),
    .rd_data_o (rd_data)
  );

  // Transmit FSM with registered router-side and client-side outputs.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      len_q     <= '0;
      inject_q  <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      parity_q  <= '0;
      cnt_q     <= '0;
      sticky_q  <= 1'b0;
      pkt_valid <= 1'b0;
      data_out  <= '0;
      tx_rej    <= 1'b0;
      tx_done   <= 1'b0;
      tx_err    <= 1'b0;
    end else begin
      tx_rej  <= 1'b0;
      tx_done <= 1'b0;
      tx_err  <= 1'b0;
      case (state_q)
        StIdle: begin
          if (tx_req) begin
            if (tx_addr == ADDR_ILLEGAL || tx_len == 6'd0) begin
              tx_rej <= 1'b1;
            end else begin
              addr_q   <= tx_addr;
              len_q    <= tx_len;
              inject_q <= tx_inject_err;
              parity_q <= pack_header(tx_len, tx_addr);
              wr_ptr_q <= '0;
              rd_ptr_q <= '0;
              state_q  <= StLoad;
            end
          end
        end
        StLoad: begin
          if (wr_en) begin
            parity_q <= parity_q ^ pld_data;
            wr_ptr_q <= wr_ptr_q + 6'd1;
            if (wr_ptr_q + 6'd1 == len_q) begin
              pkt_valid <= 1'b1;
              data_out  <= pack_header(len_q, addr_q);
              state_q   <= StHeader;
            end
          end
        end
        StHeader: begin
          // rd_ptr_q is 0 here, so rd_data is the first payload byte.
          if (!busy) begin
            data_out <= rd_data;
            rd_ptr_q <= 6'd1;
            state_q  <= StPayload;
          end
        end
        StPayload: begin
          if (!busy) begin
            if (rd_ptr_q != len_q) begin
              data_out <= rd_data;
              rd_ptr_q <= rd_ptr_q + 6'd1;
            end else begin
              pkt_valid <= 1'b0;
              data_out  <= parity_q ^ {7'b0, inject_q};
              state_q   <= StParity;
            end
          end
        end
        StParity: begin
          if (!busy) begin
            data_out <= '0;
            cnt_q    <= ErrWaitInit;
            sticky_q <= 1'b0;
            state_q  <= StErrChk;
          end
        end
        StErrChk: begin
          sticky_q <= sticky_q | err;
          if (cnt_q <= 8'd1) begin
            tx_done <= 1'b1;
            tx_err  <= sticky_q | err;
            if (MIN_GAP == 0) begin
              state_q <= StIdle;
            end else begin
              cnt_q   <= MinGapInit;
              state_q <= StGap;
            end
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        StGap: begin
          if (cnt_q <= 8'd1) begin
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_router_pkt_tx.sv
// Directed bench for router_pkt_tx with a byte scoreboard on the router side.
module tb_router_pkt_tx;

  logic       clock = 1'b0;
  logic       resetn;
  logic       tx_req;
  logic [1:0] tx_addr;
  logic [5:0] tx_len;
  logic       tx_inject_err;
  logic       req_ready;
  logic       tx_rej;
  logic       pld_valid;
  logic [7:0] pld_data;
  logic       pld_ready;
  logic       pkt_valid;
  logic [7:0] data_out;
  logic       busy;
  logic       err;
  logic       tx_done;
  logic       tx_err;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q [$];
  logic       in_pkt = 1'b0;
  logic [7:0] pl [64];

  always #5 clock = ~clock;

  router_pkt_tx #(
    .MIN_GAP  (2),
    .ERR_WAIT (3)
  ) dut (
    .clock         (clock),
    .resetn        (resetn),
    .tx_req        (tx_req),
    .tx_addr       (tx_addr),
    .tx_len        (tx_len),
    .tx_inject_err (tx_inject_err),
    .req_ready     (req_ready),
    .tx_rej        (tx_rej),
    .pld_valid     (pld_valid),
    .pld_data      (pld_data),
    .pld_ready     (pld_ready),
    .pkt_valid     (pkt_valid),
    .data_out      (data_out),
    .busy          (busy),
    .err           (err),
    .tx_done       (tx_done),
    .tx_err        (tx_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Router-side scoreboard: a byte transfers on the next rising edge when busy is low.
  always @(negedge clock) begin
    if (resetn !== 1'b1) begin
      in_pkt = 1'b0;
    end else if (pkt_valid) begin
      in_pkt = 1'b1;
      check("byte_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        if (!busy) check("pkt_byte", 32'(data_out), 32'(exp_q.pop_front()));
        else       check("hold_while_busy", 32'(data_out), 32'(exp_q[0]));
      end
    end else if (in_pkt) begin
      // Only the parity byte may remain once pkt_valid drops.
      check("no_bubble_before_parity", exp_q.size(), 1);
      if (exp_q.size() == 0) begin
        in_pkt = 1'b0;
      end else if (!busy) begin
        check("parity_byte", 32'(data_out), 32'(exp_q.pop_front()));
        in_pkt = 1'b0;
      end else begin
        check("parity_hold", 32'(data_out), 32'(exp_q[0]));
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 300) begin
      step();
      n++;
    end
    check("req_ready_wait", 32'(req_ready), 1);
  endtask

  // Queues the expected bytes, issues the request and loads pl[0..len-1];
  // returns one cycle after the last load edge (HEADER on the bus).
  task automatic run_packet(input logic [1:0] addr, input logic [5:0] len,
                            input logic inject, input logic toggle);
    logic [7:0] par;
    par = {len, addr};
    exp_q.push_back(par);
    for (int i = 0; i < int'(len); i++) begin
      exp_q.push_back(pl[i]);
      par = par ^ pl[i];
    end
    exp_q.push_back(par ^ {7'b0, inject});
    wait_ready();
    tx_req        = 1'b1;
    tx_addr       = addr;
    tx_len        = len;
    tx_inject_err = inject;
    step();
    tx_req = 1'b0;
    check("no_rej_on_legal", 32'(tx_rej), 0);
    for (int i = 0; i < int'(len); i++) begin
      if (toggle) begin
        pld_valid = 1'b0;
        step();
      end
      pld_valid = 1'b1;
      pld_data  = pl[i];
      check("pld_ready_in_load", 32'(pld_ready), 1);
      step();
    end
    pld_valid = 1'b0;
    check("pld_ready_after_load", 32'(pld_ready), 0);
    check("header_valid", 32'(pkt_valid), 1);
  endtask

  task automatic count_valid(input int exp_cycles);
    int n = 0;
    while (pkt_valid && n < 200) begin
      n++;
      step();
    end
    check("valid_run_length", n, exp_cycles);
  endtask

  task automatic wait_done(input logic exp_err);
    int n = 0;
    while (!tx_done && n < 300) begin
      step();
      n++;
    end
    check("tx_done_seen", 32'(tx_done), 1);
    check("tx_err", 32'(tx_err), 32'(exp_err));
    check("req_ready_gap0", 32'(req_ready), 0);
    step();
    check("tx_done_one_cycle", 32'(tx_done), 0);
    check("req_ready_gap1", 32'(req_ready), 0);
    step();
    check("req_ready_after_gap", 32'(req_ready), 1);
  endtask

  task automatic reject(input logic [1:0] addr, input logic [5:0] len);
    wait_ready();
    tx_req  = 1'b1;
    tx_addr = addr;
    tx_len  = len;
    step();
    tx_req = 1'b0;
    check("rej_pulse", 32'(tx_rej), 1);
    check("rej_stay_idle", 32'(req_ready), 1);
    check("rej_no_pld_ready", 32'(pld_ready), 0);
    check("rej_no_pkt_valid", 32'(pkt_valid), 0);
    step();
    check("rej_pulse_end", 32'(tx_rej), 0);
    check("rej_no_pld_ready2", 32'(pld_ready), 0);
    check("rej_no_pkt_valid2", 32'(pkt_valid), 0);
  endtask

  initial begin
    resetn        = 1'b0;
    tx_req        = 1'b0;
    tx_addr       = '0;
    tx_len        = '0;
    tx_inject_err = 1'b0;
    pld_valid     = 1'b0;
    pld_data      = '0;
    busy          = 1'b0;
    err           = 1'b0;
    #12;
    check("rst_req_ready", 32'(req_ready), 1);
    check("rst_pkt_valid", 32'(pkt_valid), 0);
    check("rst_data_out", 32'(data_out), 0);
    check("rst_tx_rej", 32'(tx_rej), 0);
    check("rst_tx_done", 32'(tx_done), 0);
    check("rst_tx_err", 32'(tx_err), 0);
    check("rst_pld_ready", 32'(pld_ready), 0);
    step();
    resetn = 1'b1;
    step();

    // Basic packet; err pulses during LOAD must not count.
    pl[0] = 8'hA5;
    pl[1] = 8'h3C;
    pl[2] = 8'h0F;
    err = 1'b1;
    run_packet(2'd1, 6'd3, 1'b0, 1'b0);
    err = 1'b0;
    check("header_byte", 32'(data_out), 32'h0D);
    count_valid(4);
    check("parity_on_bus", 32'(data_out), 32'h9B);
    wait_done(1'b0);

    // Same packet with busy stalls in HEADER and mid-payload.
    run_packet(2'd1, 6'd3, 1'b0, 1'b0);
    busy = 1'b1;
    repeat (4) begin
      check("busy_hdr_valid", 32'(pkt_valid), 1);
      step();
    end
    busy = 1'b0;
    step();
    step();
    busy = 1'b1;
    repeat (2) begin
      check("busy_pld_valid", 32'(pkt_valid), 1);
      step();
    end
    busy = 1'b0;
    count_valid(2);
    wait_done(1'b0);

    // Injected parity error; router err two cycles after the parity transfer.
    run_packet(2'd1, 6'd3, 1'b1, 1'b0);
    count_valid(4);
    check("parity_injected", 32'(data_out), 32'h9A);
    step();
    step();
    err = 1'b1;
    step();
    err = 1'b0;
    wait_done(1'b1);

    // Illegal requests.
    reject(2'd3, 6'd5);
    reject(2'd0, 6'd0);

    // Maximum length with a slow payload source.
    for (int i = 0; i < 63; i++) pl[i] = 8'(i * 37 + 11);
    run_packet(2'd0, 6'd63, 1'b0, 1'b1);
    count_valid(64);
    wait_done(1'b0);

    // Asynchronous reset in the middle of a 10-byte payload.
    for (int i = 0; i < 10; i++) pl[i] = 8'(8'hC0 + i);
    run_packet(2'd1, 6'd10, 1'b0, 1'b0);
    step();
    step();
    step();
    check("pre_reset_byte2", 32'(data_out), 32'hC2);
    #2;
    resetn = 1'b0;
    #1;
    check("async_rst_pkt_valid", 32'(pkt_valid), 0);
    check("async_rst_data_out", 32'(data_out), 0);
    check("async_rst_req_ready", 32'(req_ready), 1);
    exp_q.delete();
    in_pkt = 1'b0;
    step();
    resetn = 1'b1;
    step();
    pl[0] = 8'h5A;
    run_packet(2'd2, 6'd1, 1'b0, 1'b0);
    check("post_reset_header", 32'(data_out), 32'h06);
    count_valid(2);
    check("post_reset_parity", 32'(data_out), 32'h5C);
    wait_done(1'b0);

    repeat (3) step();
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
